v3_peak_detect: RTL and testbench

Downstream stage of the v3 shaping filter. It consumes one filtered sample per clock and detects pulses by threshold crossing with hysteresis. For each pulse it captures the maximum amplitude and its timestamp, and queues the result in a small FIFO behind a valid/ready handshake for the readout logic.

---
 rtl/v3_peak_param.sv | 33 +++
 rtl/v3_peak_fifo.sv | 74 +++++++
 rtl/v3_peak_detect.sv | 190 +++++++++++++++++++
 tb/tb_v3_peak_detect.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/v3_peak_param.sv
//-----------------------------------------------------------------------------
// v3_peak_param
//   Shared definitions for the v3 peak detector: parameter defaults, the
//   detector state encoding, the default event record and a width helper.
//-----------------------------------------------------------------------------
package v3_peak_param;

    localparam int SIZE_IN_DEF    = 17;
    localparam int TS_W_DEF       = 32;
    localparam int HYST_DEF       = 8;
    localparam int DEAD_TIME_DEF  = 16;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int MAX_WIDTH_DEF  = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    // Event record at the default widths; the top builds its own copy from
    // its actual parameters and hands it to the FIFO as a type parameter.
    typedef struct packed {
        logic signed [SIZE_IN_DEF-1:0] amp;
        logic        [TS_W_DEF-1:0]    ts;
    } peak_event_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/v3_peak_fifo.sv
//-----------------------------------------------------------------------------
// v3_peak_fifo
//   Small synchronous FIFO of event records with a first-word-fall-through
//   head. Push and pop in the same cycle are both honoured; a push while full
//   is accepted only when a pop frees a slot on the same edge.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset (pointers only)
//   push       write request
//   push_data  record to write
//   pop        consumer ready; acts only when the FIFO holds data
//   head       oldest record, zero while empty
//   valid      FIFO holds at least one record
//   full       FIFO holds DEPTH records
//
// DEPTH must be a power of two, at least 2.
//-----------------------------------------------------------------------------
module v3_peak_fifo
    import v3_peak_param::*;
#(
    parameter type T     = peak_event_t,
    parameter int  DEPTH = FIFO_DEPTH_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output T     head,
    output logic valid,
    output logic full
);

    localparam int AW = clog2_min1(DEPTH);

    // One extra pointer bit separates full from empty when the indices match.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    T            mem [DEPTH];

    logic empty;
    logic do_push;
    logic do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign valid   = !empty;

    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values; blocking = here would create order-dependent races.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: the storage array has no reset; only the pointers do. A slot is
    // never visible before it is written, and the head is forced to zero
    // while empty, so reset values appear on the outputs without resetting RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/v3_peak_detect.sv
//-----------------------------------------------------------------------------
// v3_peak_detect
//   Pulse detector behind the v3 shaping filter. A pulse starts when the
//   sample rises above threshold and ends when it falls below
//   threshold - HYST. The largest sample of the pulse (first occurrence on
//   ties) and its timestamp are queued in an event FIFO, after which input is
//   ignored for DEAD_TIME cycles.
//
// Ports:
//   clk         system clock
//   reset       asynchronous active-low reset
//   input_data  filtered sample, one per clock (signed)
//   threshold   trigger level (signed), sampled every clock
//   peak_amp    FIFO head: maximum amplitude
//   peak_time   FIFO head: timestamp of the maximum
//   peak_valid  FIFO head valid
//   peak_ready  consumer accepts head when peak_valid & peak_ready
//   overflow    sticky: an event was dropped because the FIFO was full
//   pileup_cnt  count of events rejected as too wide (0 when feature off)
//
// Build option:
//   V3_PEAK_PILEUP_REJECT_EN  when defined, pulses wider than MAX_WIDTH
//                             samples are not queued and are counted in
//                             pileup_cnt (saturating).
//-----------------------------------------------------------------------------
module v3_peak_detect
    import v3_peak_param::*;
#(
    parameter int SIZE_IN    = SIZE_IN_DEF,
    parameter int TS_W       = TS_W_DEF,
    parameter int HYST       = HYST_DEF,
    parameter int DEAD_TIME  = DEAD_TIME_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int MAX_WIDTH  = MAX_WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic signed [SIZE_IN-1:0] input_data,
    input  logic signed [SIZE_IN-1:0] threshold,
    output logic signed [SIZE_IN-1:0] peak_amp,
    output logic        [TS_W-1:0]    peak_time,
    output logic                      peak_valid,
    input  logic                      peak_ready,
    output logic                      overflow,
    output logic        [15:0]        pileup_cnt
);

    // Elaboration-time parameter sanity.
    if (DEAD_TIME < 1) begin : g_bad_dead_time
        $error("v3_peak_detect: DEAD_TIME must be >= 1");
    end
    if (MAX_WIDTH < 1) begin : g_bad_max_width
        $error("v3_peak_detect: MAX_WIDTH must be >= 1");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("v3_peak_detect: FIFO_DEPTH must be a power of two >= 2");
    end

    localparam int HO_W = clog2_min1(DEAD_TIME);

    typedef struct packed {
        logic signed [SIZE_IN-1:0] amp;
        logic        [TS_W-1:0]    ts;
    } event_t;

    state_t                    state;
    logic        [TS_W-1:0]    ts_cnt;
    logic signed [SIZE_IN-1:0] max_amp;
    logic        [TS_W-1:0]    max_ts;
    logic        [HO_W-1:0]    holdoff;

    // Re-arm level is formed one bit wider so a threshold near the negative
    // limit does not wrap to a large positive value.
    logic signed [SIZE_IN:0] in_ext;
    logic signed [SIZE_IN:0] thr_ext;
    logic signed [SIZE_IN:0] rearm_level;

    assign in_ext      = {input_data[SIZE_IN-1], input_data};
    assign thr_ext     = {threshold[SIZE_IN-1], threshold};
    assign rearm_level = thr_ext - $signed((SIZE_IN+1)'(HYST));

    logic above_thr;
    logic above_max;
    logic below_rearm;
    logic pulse_end;
    logic push;
    logic pop;
    logic fifo_full;
    event_t push_event;
    event_t head;

    assign above_thr   = input_data > threshold;
    assign above_max   = input_data > max_amp;
    assign below_rearm = in_ext < rearm_level;

    // The pulse ends on the same edge that writes the FIFO, so the push is
    // decoded from the current state and sample rather than registered.
    assign pulse_end  = (state == ARMED) && below_rearm;
    assign pop        = peak_valid && peak_ready;
    assign push_event = '{amp: max_amp, ts: max_ts};

`ifdef V3_PEAK_PILEUP_REJECT_EN
    localparam int WC_W = clog2_min1(MAX_WIDTH + 2);

    // Samples seen in the current pulse, saturating one past the limit.
    logic [WC_W-1:0] width_cnt;
    logic            too_wide;

    assign too_wide = width_cnt > WC_W'(MAX_WIDTH);
    assign push     = pulse_end && !too_wide;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            width_cnt  <= '0;
            pileup_cnt <= '0;
        end else begin
            if ((state == IDLE) && above_thr) begin
                width_cnt <= WC_W'(1);
            end else if ((state == ARMED) && !below_rearm && !too_wide) begin
                width_cnt <= width_cnt + 1'b1;
            end
            if (pulse_end && too_wide && (pileup_cnt != 16'hFFFF)) begin
                pileup_cnt <= pileup_cnt + 16'd1;
            end
        end
    end
`else
    assign push       = pulse_end;
    assign pileup_cnt = '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ts_cnt   <= '0;
            max_amp  <= '0;
            max_ts   <= '0;
            holdoff  <= '0;
            overflow <= 1'b0;
        end else begin
            ts_cnt <= ts_cnt + 1'b1;

            // A pop on the same edge frees a slot, so only a push into a
            // full FIFO with no pop loses an event.
            if (push && fifo_full && !pop) overflow <= 1'b1;

            case (state)
                IDLE: begin
                    if (above_thr) begin
                        state   <= ARMED;
                        max_amp <= input_data;
                        max_ts  <= ts_cnt;
                    end
                end
                ARMED: begin
                    if (below_rearm) begin
                        state   <= HOLDOFF;
                        holdoff <= HO_W'(DEAD_TIME - 1);
                    end else if (above_max) begin
                        max_amp <= input_data;
                        max_ts  <= ts_cnt;
                    end
                end
                HOLDOFF: begin
                    if (holdoff == '0) state <= IDLE;
                    else               holdoff <= holdoff - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    v3_peak_fifo #(
        .T     (event_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_event),
        .pop       (peak_ready),
        .head      (head),
        .valid     (peak_valid),
        .full      (fifo_full)
    );

    assign peak_amp  = head.amp;
    assign peak_time = head.ts;

endmodule

// File: tb/tb_v3_peak_detect.sv
//-----------------------------------------------------------------------------
// tb_v3_peak_detect
//   Directed pulses with hand-derived results. Expected events go into a
//   queue as stimulus is issued; a monitor pops and compares on every
//   accepted handshake. A narrow timestamp lets the wrap case be reached in
//   a few hundred cycles.
//-----------------------------------------------------------------------------
module tb_v3_peak_detect;

    localparam int SIZE_IN = 17;
    localparam int TS_W    = 8;

    typedef struct {
        logic signed [SIZE_IN-1:0] amp;
        logic        [TS_W-1:0]    ts;
    } exp_t;

    logic                      clk = 1'b0;
    logic                      reset;
    logic signed [SIZE_IN-1:0] input_data;
    logic signed [SIZE_IN-1:0] threshold;
    logic signed [SIZE_IN-1:0] peak_amp;
    logic        [TS_W-1:0]    peak_time;
    logic                      peak_valid;
    logic                      peak_ready;
    logic                      overflow;
    logic        [15:0]        pileup_cnt;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t exp_q[$];

    // Independent timestamp model: edges seen since reset was released.
    logic [TS_W-1:0] ts_model;

    v3_peak_detect #(
        .TS_W (TS_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .input_data (input_data),
        .threshold  (threshold),
        .peak_amp   (peak_amp),
        .peak_time  (peak_time),
        .peak_valid (peak_valid),
        .peak_ready (peak_ready),
        .overflow   (overflow),
        .pileup_cnt (pileup_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset) begin
        if (!reset) ts_model <= '0;
        else        ts_model <= ts_model + 1'b1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted head must match the oldest expected event.
    always @(negedge clk) begin
        if (reset && peak_valid && peak_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_event: got amp=%0d time=%0d expected none",
                         peak_amp, peak_time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("event_amp", peak_amp, e.amp);
                check("event_time", peak_time, e.ts);
            end
        end
    end

    // Present one sample; it is taken by the next edge, whose timestamp is t.
    task automatic send(input logic signed [SIZE_IN-1:0] v, output logic [TS_W-1:0] t);
        input_data = v;
        t = ts_model;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        logic [TS_W-1:0] t;
        for (int i = 0; i < n; i++) send('0, t);
    endtask

    task automatic expect_event(input logic signed [SIZE_IN-1:0] a, input logic [TS_W-1:0] t);
        exp_t e;
        e.amp = a;
        e.ts  = t;
        exp_q.push_back(e);
    endtask

    initial begin
        logic [TS_W-1:0] t;
        logic [TS_W-1:0] t_max;

        reset      = 1'b0;
        input_data = '0;
        threshold  = 17'sd100;
        peak_ready = 1'b1;

        // Reset state
        #23;
        check("rst_valid", peak_valid, 0);
        check("rst_amp", peak_amp, 0);
        check("rst_time", peak_time, 0);
        check("rst_overflow", overflow, 0);
        check("rst_pileup", pileup_cnt, 0);
        #4 reset = 1'b1;
        @(posedge clk);
        #1;

        // Basic pulse: max 200, valid exactly one cycle after the 90 sample
        send(0, t); send(50, t); send(120, t); send(200, t_max); send(180, t);
        expect_event(200, t_max);
        send(90, t);
        check("basic_valid_next_cycle", peak_valid, 1);
        send(0, t);
        check("basic_valid_one_cycle", peak_valid, 0);
        idle(20);

        // Dip to 95 stays above the re-arm level 92: one event at 210
        send(0, t); send(120, t); send(200, t); send(95, t); send(210, t_max); send(150, t);
        expect_event(210, t_max);
        send(0, t);
        idle(20);

        // Dead time: activity through cycle 16 after pulse end is ignored,
        // a crossing at cycle 17 starts a new pulse
        send(250, t_max);
        expect_event(250, t_max);
        send(0, t);
        for (int k = 1; k <= 9; k++) send(0, t);
        for (int k = 10; k <= 16; k++) send(300, t);
        send(130, t_max);
        expect_event(130, t_max);
        send(0, t);
        idle(20);

        // Negative samples never trigger a positive threshold
        for (int k = 0; k < 5; k++) send(-5000, t);
        idle(3);
        check("neg_no_event", peak_valid, 0);

        // Negative threshold: -100 > -200, ends below -208
        threshold = -17'sd200;
        send(-250, t); send(-100, t_max); send(-150, t);
        expect_event(-100, t_max);
        send(-300, t);
        idle(20);
        threshold = 17'sd100;

        // Overflow: five events with no consumer, the fifth is dropped
        peak_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(17'(200 + i), t_max);
            if (i < 4) expect_event(17'(200 + i), t_max);
            send(0, t);
            if (i == 3) check("ovf_not_yet", overflow, 0);
            if (i == 4) check("ovf_set", overflow, 1);
            if (i == 1) begin
                check("hold_valid", peak_valid, 1);
                check("hold_amp_early", peak_amp, exp_q[0].amp);
            end
            idle(16);
        end
        check("hold_amp", peak_amp, exp_q[0].amp);
        check("hold_time", peak_time, exp_q[0].ts);
        peak_ready = 1'b1;
        idle(8);
        check("drain_valid", peak_valid, 0);
        check("drain_all", exp_q.size(), 0);
        check("ovf_sticky", overflow, 1);

        // Wide pulse: 70 samples above threshold
        send(200, t_max);
        for (int k = 1; k < 70; k++) send(200, t);
`ifdef V3_PEAK_PILEUP_REJECT_EN
        send(0, t);
        check("pileup_count", pileup_cnt, 1);
`else
        expect_event(200, t_max);
        send(0, t);
        check("pileup_off", pileup_cnt, 0);
`endif
        idle(20);

        // Reset mid-pulse: outputs clear, nothing is reported afterwards
        send(200, t); send(220, t);
        #2 reset = 1'b0;
        input_data = '0;
        #1;
        check("midrst_valid", peak_valid, 0);
        check("midrst_amp", peak_amp, 0);
        check("midrst_time", peak_time, 0);
        check("midrst_overflow", overflow, 0);
        check("midrst_pileup", pileup_cnt, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        idle(20);
        check("midrst_no_event", peak_valid, 0);

        // Timestamp wrap: max sample lands on wrapped timestamp 2
        while (ts_model != 8'd253) send(0, t);
        send(0, t); send(0, t); send(0, t); send(0, t);
        send(150, t); send(160, t);
        expect_event(160, 8'd2);
        send(0, t);
        idle(20);

        check("final_queue_empty", exp_q.size(), 0);
        check("final_valid", peak_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
